// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle HI/LO arithmetic unit for the execute stage.
// Handles MULT/MULTU, MADD/MADDU, MSUB/MSUBU and (optionally) DIV/DIVU with a
// restoring divider producing one quotient bit per cycle.
//
// Optional feature macro: MULDIV_DIV_EN builds the divider, the DIV state and
// the div_by_zero logic. Without it, op 6/7 complete in one cycle with no
// HI/LO write and zero results.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   start_i, op_i          request and opcode from EX (held while stalled)
//   operand_a_i/_b_i       rs / rt, captured on accept
//   hi_i, lo_i             forwarded current HI/LO, sampled in the ACC cycle
//   cancel_i               pipeline flush, aborts any operation
//   stall_i                stage held by another stall source (holds DONE)
//   stop_req_o             stall request to pipeline control
//   busy_o, done_o         not idle / result valid
//   whilo_o                HI/LO write enable
//   hi_o, lo_o             result, zero outside DONE
//   div_by_zero_o          divide attempted with operand_b == 0
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             cancel_i,
    input  logic             stall_i,
    output logic             stop_req_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             whilo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_ACC, S_DIV, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [1:0]           kind_q;      // op[2:1]: 00 mul, 01 madd, 10 msub, 11 div
    logic                 neg_q;       // product / quotient sign flip
    logic [WIDTH-1:0]     a_q, b_q;    // operand magnitudes; a_q doubles as quotient shifter
    logic [2*WIDTH-1:0]   res_q;       // holds the product in ACC, then the final result
    logic                 nowr_q;      // completion without a HI/LO write

    logic                 accept, op_signed, op_div, sa, sb, b_zero;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   mul_full, mul_p, hilo;

    assign accept    = (state_q == S_IDLE) && start_i && !cancel_i;
    assign op_signed = ~op_i[0];
    assign op_div    = (op_i[2:1] == 2'b11);
    assign sa        = op_signed & operand_a_i[WIDTH-1];
    assign sb        = op_signed & operand_b_i[WIDTH-1];
    assign b_zero    = (operand_b_i == '0);
    assign mag_a     = sa ? -operand_a_i : operand_a_i;
    assign mag_b     = sb ? -operand_b_i : operand_b_i;

    assign mul_full  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    assign mul_p     = neg_q ? -mul_full : mul_full;
    assign hilo      = {hi_i, lo_i};

`ifdef MULDIV_DIV_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic             rneg_q, dbz_q, div_last;
    logic [WIDTH:0]   rsh, rdiff;
    logic [WIDTH-1:0] q_nxt, r_nxt, q_fin, r_fin;

    // Restoring step: shift the next dividend bit into the partial remainder
    // and keep the subtraction only when it does not go negative.
    assign rsh      = {rem_q, a_q[WIDTH-1]};
    assign rdiff    = rsh - {1'b0, b_q};
    assign q_nxt    = {a_q[WIDTH-2:0], ~rdiff[WIDTH]};
    assign r_nxt    = rdiff[WIDTH] ? rsh[WIDTH-1:0] : rdiff[WIDTH-1:0];
    assign q_fin    = neg_q  ? -q_nxt : q_nxt;
    assign r_fin    = rneg_q ? -r_nxt : r_nxt;
    assign div_last = (cnt_q == CW'(WIDTH-1));
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; cancel overrides every transition
    always_comb begin
        state_d = state_q;
        if (cancel_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    if (op_div) begin
`ifdef MULDIV_DIV_EN
                        state_d = b_zero ? S_DONE : S_DIV;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_MUL;
                    end
                end
                S_MUL:  state_d = (kind_q == 2'b00) ? S_DONE : S_ACC;
                S_ACC:  state_d = S_DONE;
`ifdef MULDIV_DIV_EN
                S_DIV:  if (div_last) state_d = S_DONE;
`endif
                S_DONE: if (!stall_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decode from registered state only, except the accept term of stop_req
    always_comb begin
        stop_req_o = accept || (state_q == S_MUL) || (state_q == S_ACC) || (state_q == S_DIV);
        busy_o     = (state_q != S_IDLE);
        done_o     = (state_q == S_DONE);
        whilo_o    = done_o && !nowr_q;
        hi_o       = done_o ? res_q[2*WIDTH-1:WIDTH] : '0;
        lo_o       = done_o ? res_q[WIDTH-1:0]       : '0;
`ifdef MULDIV_DIV_EN
        div_by_zero_o = done_o && dbz_q;
`else
        div_by_zero_o = 1'b0;
`endif
    end

    // Datapath
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            kind_q <= '0;
            neg_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            nowr_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            cnt_q  <= '0;
            rem_q  <= '0;
            rneg_q <= 1'b0;
            dbz_q  <= 1'b0;
`endif
        end else if (accept) begin
            kind_q <= op_i[2:1];
            neg_q  <= sa ^ sb;
            a_q    <= mag_a;
            b_q    <= mag_b;
            res_q  <= '0;  // zero result for the no-write divide completions
`ifdef MULDIV_DIV_EN
            nowr_q <= op_div && b_zero;
            dbz_q  <= op_div && b_zero;
            cnt_q  <= '0;
            rem_q  <= '0;
            rneg_q <= sa;
`else
            nowr_q <= op_div;
`endif
        end else begin
            case (state_q)
                S_MUL: res_q <= mul_p;
                S_ACC: res_q <= kind_q[1] ? (hilo - res_q) : (hilo + res_q);
`ifdef MULDIV_DIV_EN
                S_DIV: begin
                    a_q   <= q_nxt;
                    rem_q <= r_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (div_last) res_q <= {r_fin, q_fin};
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_ni, start_i, cancel_i, stall_i;
    logic [2:0]   op_i;
    logic [W-1:0] operand_a_i, operand_b_i, hi_i, lo_i;
    logic         stop_req_o, busy_o, done_o, whilo_o, div_by_zero_o;
    logic [W-1:0] hi_o, lo_o;

    ex_muldiv #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .hi_i(hi_i), .lo_i(lo_i), .cancel_i(cancel_i), .stall_i(stall_i),
        .stop_req_o(stop_req_o), .busy_o(busy_o), .done_o(done_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .div_by_zero_o(div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] res;
        logic        whilo;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Reference model: {HI,LO} for every op, from plain 64-bit arithmetic
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b, hi, lo);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] sp, up, hl;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sp = sa * sb;
        up = {32'b0, a} * {32'b0, b};
        hl = {hi, lo};
        case (op)
            3'd0: return sp;
            3'd1: return up;
            3'd2: return hl + sp;
            3'd3: return hl + up;
            3'd4: return hl - sp;
            3'd5: return hl - up;
            3'd6: begin
                if (!DIV_EN || b == 0) return 64'd0;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (!DIV_EN || b == 0) return 64'd0;
                return {a % b, a / b};
            end
        endcase
    endfunction

    // One transaction: push expectation at accept, pop and compare at done.
    // hi_late replaces hi_i right after the accept edge; stall_n holds DONE.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, b, hi, lo,
                         input logic [31:0] hi_late, input int stall_n);
        exp_t e, g;
        int cyc;
        bit got;
        logic [63:0] held;
        e.res   = model(op, a, b, hi_late, lo);
        e.whilo = (op < 3'd6) || (DIV_EN && b != 0);
        e.dbz   = DIV_EN && op >= 3'd6 && b == 0;
        e.lat   = (op < 3'd2) ? 2 : (op < 3'd6) ? 3 : (DIV_EN && b != 0) ? W + 1 : 1;
        @(negedge clk_i);
        op_i = op; operand_a_i = a; operand_b_i = b; hi_i = hi; lo_i = lo; start_i = 1'b1;
        #1 chk("stop_req_accept", stop_req_o, 1);
        sb_q.push_back(e);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        hi_i = hi_late;
        cyc = 1;
        got = 0;
        while (cyc <= W + 8 && !got) begin
            if (done_o) got = 1;
            else begin
                if (stop_req_o !== 1'b1) chk("stop_req_busy", stop_req_o, 1);
                @(posedge clk_i); #1;
                cyc++;
            end
        end
        g = sb_q.pop_front();
        if (!got) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("latency", 64'(cyc), 64'(g.lat));
            chk("result", {hi_o, lo_o}, g.res);
            chk("whilo", whilo_o, g.whilo);
            chk("div_by_zero", div_by_zero_o, g.dbz);
            chk("stop_req_done", stop_req_o, 0);
            if (stall_n > 0) begin
                held = {hi_o, lo_o};
                stall_i = 1'b1;
                start_i = 1'b1;  // must not be re-accepted while held
                for (int k = 0; k < stall_n; k++) begin
                    @(posedge clk_i); #1;
                    chk("stall_hold_done", {done_o, whilo_o, stop_req_o}, {61'd0, 1'b1, g.whilo, 1'b0});
                    chk("stall_hold_res", {hi_o, lo_o}, held);
                end
                stall_i = 1'b0;
                start_i = 1'b0;
            end
        end
        @(posedge clk_i); #1;
        chk("exit_idle", {busy_o, done_o}, 0);
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; cancel_i = 1'b0; stall_i = 1'b0;
        op_i = '0; operand_a_i = '0; operand_b_i = '0; hi_i = '0; lo_i = '0;
        repeat (3) @(posedge clk_i);
        #1 chk("reset_state", {stop_req_o, busy_o, done_o, whilo_o, div_by_zero_o, hi_o, lo_o}, 0);
        rst_ni = 1'b1;

        // Directed cases
        do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 32'd0, 0);
        do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 32'd0, 0);
        do_op(3'd3, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'hFFFF_FFFF, 32'd0, 0);
        do_op(3'd4, 32'd2, 32'd3, 32'd0, 32'd5, 32'd0, 0);
        do_op(3'd4, 32'd2, 32'd3, 32'h1234_5678, 32'd5, 32'd0, 0);   // ACC-cycle HI used
        do_op(3'd2, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 32'd0, 0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 0);
        do_op(3'd7, 32'd100, 32'd0, 32'd0, 32'd0, 32'd0, 0);
        do_op(3'd7, 32'hFFFF_FFF9, 32'd10, 32'd0, 32'd0, 32'd0, 0);
        do_op(3'd0, 32'd7, 32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0, 2);   // stall in DONE

        // Cancel mid-operation, then an immediate MULT
        @(negedge clk_i);
        op_i = DIV_EN ? 3'd6 : 3'd2; operand_a_i = 32'd1000; operand_b_i = 32'd7; start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        if (DIV_EN) repeat (10) @(posedge clk_i);   // reach iteration 10
        #1 chk("cancel_busy_before", busy_o, 1);
        cancel_i = 1'b1;
        @(posedge clk_i); #1 cancel_i = 1'b0;
        chk("cancel_idle", {busy_o, done_o, whilo_o, stop_req_o}, 0);
        do_op(3'd0, 32'd12345, 32'd678, 32'd0, 32'd0, 32'd0, 0);

        // Reset low during ACC
        @(negedge clk_i);
        op_i = 3'd3; operand_a_i = 32'd9; operand_b_i = 32'd9; start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        @(posedge clk_i); #1;
        chk("acc_busy", {busy_o, stop_req_o}, 2'b11);
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        chk("reset_in_acc", {stop_req_o, busy_o, done_o, whilo_o, div_by_zero_o, hi_o, lo_o}, 0);
        rst_ni = 1'b1;

        // Random mix
        for (int i = 0; i < 24; i++) begin
            logic [2:0] op;
            logic [31:0] a, b, h, l;
            op = 3'($urandom_range(0, 7));
            a = $urandom; b = (i % 6 == 5) ? 32'd0 : $urandom;
            if (i % 4 == 1) b = 32'($urandom_range(1, 20));
            h = $urandom; l = $urandom;
            do_op(op, a, b, h, l, (i % 3 == 0) ? ~h : h, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised multi-cycle HI/LO arithmetic unit for the execute stage. It is the successor to the execute stage's inline multiply and two-cycle madd/msub handling. It covers signed/unsigned multiply, multiply-accumulate, multiply-subtract and an iterative restoring divider at configurable width. The unit raises a stall request to the pipeline control while it works and presents a single HI/LO write on completion.

## Interface
- WIDTH, 32: operand and HI/LO register width; products are 2*WIDTH.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clock.
- start  in  1  request from EX; held by the stalled instruction; accepted only in IDLE.
- op  in  3  0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 DIV, 7 DIVU.
- operand_a / operand_b  in  WIDTH  rs / rt values; captured on accept.
- hi_input / lo_input  in  WIDTH  forwarded current HI/LO, already resolved through mem/wb.
- cancel  in  1  pipeline flush; aborts any operation.
- stall_input  in  1  stage held by another stall source.
- stop_req  out  1  stall request to pipeline control.
- busy  out  1  state is not IDLE.
- done  out  1  result valid.
- whilo_output  out  1  HI/LO write enable.
- hi_output / lo_output  out  WIDTH  result.
- div_by_zero  out  1  divide with operand_b == 0.

## Operation
- States:
  - IDLE
  - MUL: register the 2*WIDTH product.
  - ACC: add or subtract against {hi_input, lo_input}.
  - DIV: WIDTH iterations.
  - DONE
- Accept: in IDLE with start=1 and cancel=0, capture op and operands.
  - Multiply ops go to MUL.
  - DIV/DIVU with operand_b != 0 go to DIV.
  - DIV/DIVU with operand_b == 0 go to DONE.
- Signed multiply:
  - Take magnitudes.
  - Compute the unsigned product.
  - Negate the product if the operand sign bits differ.
  - Unsigned ops use the raw operands.
- MUL → DONE for MULT/MULTU, with result = product.
- MUL → ACC for MADD/MSUB.
- ACC samples hi_input/lo_input in the ACC cycle, not at accept. Result is {hi,lo} + product (MADD*) or {hi,lo} − product (MSUB*), modulo 2^(2*WIDTH). ACC → DONE.
- DIV, one quotient bit per cycle over magnitudes:
  - A counter runs 0..WIDTH-1.
  - On the last iteration, apply the signs and go to DONE.
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
  - Most-negative ÷ −1 gives LO = 2^(WIDTH-1) (wraps), HI = 0.
- Divide by zero: DONE with div_by_zero=1 and whilo_output=0. HI/LO are not written; hi_output/lo_output = 0.
- DONE: done=1. whilo_output=1, except for divide by zero.
  - If stall_input=1, DONE is held with outputs stable, and start is not re-accepted.
  - If stall_input=0, go to IDLE next edge.
- cancel=1 in any state: IDLE next edge, no done/whilo. cancel has priority over start and over DONE.
- Precedence at an edge: reset > cancel > normal transition.

## Timing
- Cycle 0 is the accept edge's cycle (IDLE with start). done asserts in:
  - cycle 2 for MULT/MULTU;
  - cycle 3 for MADD*/MSUB*;
  - cycle WIDTH+1 for DIV/DIVU (33 at WIDTH=32);
  - cycle 1 for divide by zero.
- stop_req (combinational) = (IDLE & start & ~cancel) | MUL | ACC | DIV.
  - stop_req=0 in DONE, so the instruction advances that cycle carrying whilo_output/hi/lo.
- done, whilo_output, div_by_zero, busy and hi/lo outputs decode from registered state and registers; there is no combinational path from start.
- Reset values:
  - state IDLE;
  - stop_req, busy, done, whilo_output, div_by_zero = 0;
  - hi_output = lo_output = 0;
  - internal counters, product and operand registers = 0.
- Reset low mid-operation aborts it; outputs are 0 after that edge.
- A new start is accepted in the cycle after DONE exits, so there is no dead cycle beyond that.

## Configuration
- MULDIV_DIV_EN defined: the divider, DIV state and div_by_zero logic are built.
- MULDIV_DIV_EN undefined:
  - no divider hardware;
  - op 6/7 go IDLE → DONE, with done at cycle 1, whilo_output=0, div_by_zero=0, and hi/lo outputs 0;
  - div_by_zero is tied 0.

## Test plan
- MULT with operand_a=0xFFFFFFFE, operand_b=3.
  - stop_req=1 in cycles 0–1.
  - Cycle 2: done=1, whilo=1, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MADDU with a=0x00010000, b=0x00010000, hi_input=0, lo_input=0xFFFFFFFF → cycle 3: HI=0x00000001, LO=0xFFFFFFFF.
- MSUB with a=2, b=3, hi_input=0, lo_input=5.
  - Cycle 3: HI=LO=0xFFFFFFFF.
  - Repeat with hi_input changed between accept and ACC: the ACC-cycle value is used.
- DIV with a=0xFFFFFFF9 (−7), b=2 → cycle 33: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV with 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU with b=0 → cycle 1: done=1, div_by_zero=1, whilo=0. Build without MULDIV_DIV_EN → div_by_zero stays 0.
- Abort and hold cases:
  - cancel in DIV iteration 10 → busy=0 next cycle, no done; a following MULT start is accepted immediately.
  - reset low in ACC → all outputs 0 after that edge.
  - stall_input=1 for 2 cycles in DONE → done held for 3 cycles with no restart.
